stream_window_buffer: RTL and testbench
=======================================

// Module: stream_window_buffer
// PURPOSE
// Circular sample buffer for the streaming convolution datapath. It accepts one
// pixel per cycle through a valid/ready handshake and emits N-tap sliding
// windows, advanced by STRIDE, through a registered valid/ready output for the
// MAC array. It replaces the address-driven write/read memory with pointer,
// occupancy and row-boundary control.
// PARAMETERS
// DATA_W  8   sample width in bits
// DEPTH   24  buffer entries; need not be a power of 2; DEPTH >= N
// N       8   taps per window
// STRIDE  1   samples retired per emitted window; 1 <= STRIDE <= N
// PORTS
// clk        in   1         clock; all state changes on its rising edge
// rst        in   1         synchronous reset, active-high
// in_valid   in   1         in_data/in_last are valid
// in_ready   out  1         buffer can accept a sample this cycle
// in_data    in   DATA_W    incoming sample
// in_last    in   1         qualifies the final sample of a row
// out_valid  out  1         out_data holds a complete window
// out_ready  in   1         consumer takes the window this cycle
// out_data   out  N*DATA_W  window [0:N-1]; tap 0 is the oldest sample
// out_last   out  1         window is the last one of its row
// occupancy  out  clog2(DEPTH+1)  samples stored and not yet retired
// BEHAVIOUR
// - Reset (rst=1 at clock edge):
//   - State: wr_ptr=0, rd_ptr=0, occupancy=0, state=RUN.
//   - Outputs: out_valid=0, out_last=0, out_data=0. in_ready=0 while rst is high.
//   - Reset mid-row discards all stored samples and any held window.
// - Input accept: in_valid && in_ready.
//   - Accept writes buf[wr_ptr] and advances wr_ptr.
//   - Pointers wrap from DEPTH-1 to 0 (modulo DEPTH, not a bit-mask).
// - Load: (!out_valid || out_ready) && occupancy >= N && state != DROP.
//   - out_data[i] <= buf[(rd_ptr+i) mod DEPTH] for i = 0..N-1.
//   - out_valid <= 1, rd_ptr += STRIDE (mod DEPTH).
// - If out_valid && out_ready and there is no load, out_valid <= 0.
// - Occupancy: next = occupancy + accept - (load ? STRIDE : 0).
//   - Accept and load in the same cycle are both applied.
//   - Occupancy never exceeds DEPTH and never goes below 0.
// - Reads see only samples written on earlier edges; there is no write-to-read bypass.
// - Minimum latency: a window whose newest sample is accepted in cycle t has
//   out_valid=1 in cycle t+2.
// - out_data and out_last stay stable while out_valid && !out_ready.
// - FSM:
//   - RUN:
//     - in_ready = (occupancy < DEPTH).
//     - Accept with in_last=1 -> TAIL.
//     - Loads here always set out_last=0.
//   - TAIL:
//     - in_ready = 0.
//     - Loads continue.
//     - A load with occupancy-STRIDE < N sets out_last=1 and goes to DROP.
//     - If occupancy < N with no load, go to DROP (short row: no window, no out_last).
//   - DROP (exactly 1 cycle):
//     - in_ready = 0, no load.
//     - rd_ptr <= wr_ptr, occupancy <= 0, then -> RUN.
//     - Leftover tail samples (fewer than N) are discarded.
//     - A window held in the output register is unaffected and waits for out_ready.
// - A full buffer with out_ready=0 holds in_ready=0. Nothing is overwritten or lost.
// - Elaboration checks: DEPTH >= N, 1 <= STRIDE <= N.
// TESTING
// - T1. N=3, DEPTH=8, STRIDE=1; row 1..6 with in_last on 6; out_ready=1.
//   -> windows {1,2,3},{2,3,4},{3,4,5},{4,5,6}; out_last only on {4,5,6};
//   -> first out_valid 2 cycles after sample 3 is accepted.
// - T2. N=3, STRIDE=2.
//   -> row 1..7 gives {1,2,3},{3,4,5},{5,6,7}(last).
//   -> row 11..16 gives {11,12,13},{13,14,15}(last); sample 16 is dropped.
// - T3. N=3, DEPTH=8; out_ready=0, 10 samples offered.
//   -> occupancy climbs to 8 and in_ready=0 at occupancy 8; window {1,2,3} is held stable.
//   -> after out_ready=1, windows come out in order with no loss or duplication.
// - T4. N=4, DEPTH=6 (not a power of 2); ramp 0..39 in one row; random out_ready.
//   -> window k = {k,k+1,k+2,k+3} for k=0..36 across pointer wraps; out_last on k=36.
// - T5. N=3; short row 1,2 (in_last on 2), then row 10,11,12 (in_last on 12).
//   -> no window for the short row; then {10,11,12} with out_last=1.
// - T6. rst pulsed for 1 cycle mid-row while out_valid=1 and occupancy=5.
//   -> next cycle out_valid=0, out_last=0, occupancy=0; in_ready=1 once rst=0.
//   -> the next row is windowed from its first sample.

Source files
------------

// File: rtl/stream_window_buffer.sv
// Circular sample buffer that turns a pixel stream into N-tap sliding windows
// advanced by STRIDE, with row-end handling for the MAC array.
//
// state | meaning
// RUN   | accepting samples, emitting windows with out_last=0
// TAIL  | row ended; drain remaining full windows, flag the final one
// DROP  | one cycle: discard leftover tail samples, realign rd_ptr to wr_ptr
module stream_window_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 24,
  parameter int N      = 8,
  parameter int STRIDE = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*DATA_W-1:0]          out_data,
  output logic                         out_last,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [AW:0]   DEPTH_P  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   STRIDE_P = (AW+1)'(STRIDE);
  localparam logic [AW:0]   ONE_P    = (AW+1)'(1);
  localparam logic [OW-1:0] DEPTH_O  = OW'(DEPTH);
  localparam logic [OW-1:0] N_O      = OW'(N);
  localparam logic [OW-1:0] STRIDE_O = OW'(STRIDE);
  localparam logic [OW-1:0] ONE_O    = OW'(1);
  localparam logic [OW:0]   TAIL_LIM = (OW+1)'(N + STRIDE);

  if (DEPTH < N) begin : g_chk_depth
    $error("stream_window_buffer: DEPTH must be >= N");
  end
  if (STRIDE < 1 || STRIDE > N) begin : g_chk_stride
    $error("stream_window_buffer: STRIDE must be in 1..N");
  end

  typedef enum logic [1:0] {RUN, TAIL, DROP} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                accept, load, last_nxt;
  logic [OW-1:0]       occ_nxt;
  logic [N*DATA_W-1:0] window;

  // Pointer add modulo DEPTH; operands are always < DEPTH so one subtract suffices.
  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input logic [AW:0] a);
    logic [AW:0] s;
    s = {1'b0, p} + a;
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[AW-1:0];
  endfunction

  assign in_ready = !rst && (state == RUN) && (occupancy < DEPTH_O);
  assign accept   = in_valid && in_ready;
  assign load     = (!out_valid || out_ready) && (occupancy >= N_O) && (state != DROP);

  always_comb begin
    window = '0;
    for (int i = 0; i < N; i++) begin
      window[i*DATA_W +: DATA_W] = mem[wrap_add(rd_ptr, (AW+1)'(i))];
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = 1'b0;
    case (state)
      RUN: begin
        if (accept && in_last) state_nxt = TAIL;
      end
      TAIL: begin
        if (load) begin
          // Final window: fewer than N samples would remain after retiring STRIDE.
          if ({1'b0, occupancy} < TAIL_LIM) begin
            last_nxt  = 1'b1;
            state_nxt = DROP;
          end
        end else if (occupancy < N_O) begin
          state_nxt = DROP;
        end
      end
      DROP:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase

    occ_nxt = occupancy;
    if (accept) occ_nxt = occ_nxt + ONE_O;
    if (load)   occ_nxt = occ_nxt - STRIDE_O;
    if (state == DROP) occ_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      state     <= state_nxt;
      occupancy <= occ_nxt;
      if (accept) wr_ptr <= wrap_add(wr_ptr, ONE_P);
      if (state == DROP)  rd_ptr <= wr_ptr;
      else if (load)      rd_ptr <= wrap_add(rd_ptr, STRIDE_P);
      if (load) begin
        out_data  <= window;
        out_valid <= 1'b1;
        out_last  <= last_nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_window_buffer.sv
// Directed bench for stream_window_buffer: cycle table for the basic row, then
// scoreboarded sequences for stride, backpressure, wrap, short row and reset.
module tb_stream_window_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_last, out_ready_man, rnd_mode, rnd_bit, sb_on;
  logic [7:0] in_data;
  int         sel, checks, failures;
  logic       out_ready_eff;
  assign out_ready_eff = rnd_mode ? rnd_bit : out_ready_man;

  logic        iv0, iv1, iv2, or0, or1, or2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, ol0, ol1, ol2;
  logic [23:0] od0, od1;
  logic [31:0] od2;
  logic [3:0]  occ0, occ1;
  logic [2:0]  occ2;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);
  assign or0 = out_ready_eff && (sel == 0);
  assign or1 = out_ready_eff && (sel == 1);
  assign or2 = out_ready_eff && (sel == 2);

  stream_window_buffer #(.DATA_W(8), .DEPTH(8), .N(3), .STRIDE(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_data(in_data),
    .in_last(in_last), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .out_last(ol0), .occupancy(occ0));
  stream_window_buffer #(.DATA_W(8), .DEPTH(8), .N(3), .STRIDE(2)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_data(in_data),
    .in_last(in_last), .out_valid(ov1), .out_ready(or1), .out_data(od1),
    .out_last(ol1), .occupancy(occ1));
  stream_window_buffer #(.DATA_W(8), .DEPTH(6), .N(4), .STRIDE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(in_data),
    .in_last(in_last), .out_valid(ov2), .out_ready(or2), .out_data(od2),
    .out_last(ol2), .occupancy(occ2));

  logic        ir_m, ov_m, ol_m;
  logic [31:0] od_m;
  logic [7:0]  occ_m;
  always_comb begin
    ir_m = ir0; ov_m = ov0; ol_m = ol0; od_m = {8'h00, od0}; occ_m = {4'h0, occ0};
    if (sel == 1) begin
      ir_m = ir1; ov_m = ov1; ol_m = ol1; od_m = {8'h00, od1}; occ_m = {4'h0, occ1};
    end else if (sel == 2) begin
      ir_m = ir2; ov_m = ov2; ol_m = ol2; od_m = od2; occ_m = {5'h00, occ2};
    end
  end

  typedef struct packed {logic [31:0] data; logic last;} win_t;
  win_t q[$];

  typedef struct {
    logic iv; logic [7:0] d; logic l; logic r;
    logic e_ov; logic [31:0] e_data; logic e_last; logic [7:0] e_occ; logic e_ir;
  } vec_t;
  vec_t tv[9];

  logic        ir_s, ov_s, ol_s;
  logic [31:0] od_s;
  logic [7:0]  occ_s;

  function automatic logic [31:0] w3(input int a, input int b, input int c);
    return {8'h00, 8'(c), 8'(b), 8'(a)};
  endfunction
  function automatic logic [31:0] w4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  // One cycle: sample at negedge, score any handshake, then step past the posedge.
  task automatic tick();
    win_t e;
    @(negedge clk);
    ir_s = ir_m; ov_s = ov_m; ol_s = ol_m; od_s = od_m; occ_s = occ_m;
    if (sb_on && ov_m && out_ready_eff) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: got window %h last=%0b, required no window", od_m, ol_m);
      end else begin
        e = q.pop_front();
        if (od_m !== e.data || ol_m !== e.last) begin
          failures++;
          $display("FAIL sb_window: got %h last=%0b, required %h last=%0b",
                   od_m, ol_m, e.data, e.last);
        end
      end
    end
    @(posedge clk);
    #1;
    if (rnd_mode) rnd_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic done;
    done = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l;
    for (int n = 0; n < 200 && !done; n++) begin
      tick();
      if (ir_s) done = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk($sformatf("send_accept[%0d]", d), 32'(done), 32'd1);
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget && q.size() > 0; n++) tick();
    repeat (6) tick();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready_man = 1'b0; rnd_mode = 1'b0; rnd_bit = 1'b0;
    sel = 0; sb_on = 1'b0; checks = 0; failures = 0;

    tv[0] = '{1'b1, 8'd1, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 8'd0, 1'b1};
    tv[1] = '{1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 8'd1, 1'b1};
    tv[2] = '{1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 8'd2, 1'b1};
    tv[3] = '{1'b1, 8'd4, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 8'd3, 1'b1};
    tv[4] = '{1'b1, 8'd5, 1'b0, 1'b1, 1'b1, w3(1, 2, 3), 1'b0, 8'd3, 1'b1};
    tv[5] = '{1'b1, 8'd6, 1'b1, 1'b1, 1'b1, w3(2, 3, 4), 1'b0, 8'd3, 1'b1};
    tv[6] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, w3(3, 4, 5), 1'b0, 8'd3, 1'b0};
    tv[7] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b1, w3(4, 5, 6), 1'b1, 8'd2, 1'b0};
    tv[8] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 32'h0,       1'b0, 8'd0, 1'b1};

    @(posedge clk); #1;
    tick();
    chk("rst_in_ready", 32'(ir_s), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_out_valid", 32'(ov_s), 32'd0);
    chk("rst_out_last", 32'(ol_s), 32'd0);
    chk("rst_out_data", od_s, 32'd0);
    chk("rst_occupancy", 32'(occ_s), 32'd0);

    // T1: cycle-exact row 1..6, N=3, STRIDE=1
    for (int i = 0; i < 9; i++) begin
      in_valid = tv[i].iv; in_data = tv[i].d; in_last = tv[i].l; out_ready_man = tv[i].r;
      tick();
      chk($sformatf("t1_out_valid[%0d]", i), 32'(ov_s), 32'(tv[i].e_ov));
      chk($sformatf("t1_occupancy[%0d]", i), 32'(occ_s), 32'(tv[i].e_occ));
      chk($sformatf("t1_in_ready[%0d]", i), 32'(ir_s), 32'(tv[i].e_ir));
      if (tv[i].e_ov) begin
        chk($sformatf("t1_out_data[%0d]", i), od_s, tv[i].e_data);
        chk($sformatf("t1_out_last[%0d]", i), 32'(ol_s), 32'(tv[i].e_last));
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    sb_on = 1'b1;

    // T3: backpressure fills the buffer, held window stays stable
    sel = 0; out_ready_man = 1'b0;
    for (int k = 1; k <= 8; k++) q.push_back(win_t'{w3(k, k + 1, k + 2), (k == 8)});
    for (int k = 1; k <= 9; k++) send(8'(k), 1'b0);
    in_valid = 1'b1; in_data = 8'd10; in_last = 1'b1;
    repeat (4) begin
      tick();
      chk("t3_full_in_ready", 32'(ir_s), 32'd0);
      chk("t3_full_occupancy", 32'(occ_s), 32'd8);
      chk("t3_hold_valid", 32'(ov_s), 32'd1);
      chk("t3_hold_data", od_s, w3(1, 2, 3));
    end
    out_ready_man = 1'b1;
    send(8'd10, 1'b1);
    drain(100);

    // T2: STRIDE=2; second row fed under backpressure so its last window loads in TAIL
    sel = 1; out_ready_man = 1'b1;
    q.push_back(win_t'{w3(1, 2, 3), 1'b0});
    q.push_back(win_t'{w3(3, 4, 5), 1'b0});
    q.push_back(win_t'{w3(5, 6, 7), 1'b1});
    for (int k = 1; k <= 7; k++) send(8'(k), (k == 7));
    drain(50);
    out_ready_man = 1'b0;
    q.push_back(win_t'{w3(11, 12, 13), 1'b0});
    q.push_back(win_t'{w3(13, 14, 15), 1'b1});
    for (int k = 11; k <= 16; k++) send(8'(k), (k == 16));
    repeat (3) tick();
    out_ready_man = 1'b1;
    drain(50);
    chk("t2_occ_after_drop", 32'(occ_s), 32'd0);

    // T4: N=4, DEPTH=6 ramp across pointer wraps with random out_ready
    sel = 2; rnd_mode = 1'b1;
    for (int k = 0; k <= 36; k++) q.push_back(win_t'{w4(k, k + 1, k + 2, k + 3), (k == 36)});
    for (int k = 0; k <= 39; k++) send(8'(k), (k == 39));
    drain(400);
    rnd_mode = 1'b0;

    // T5: short row yields nothing, next row is windowed from its first sample
    sel = 0; out_ready_man = 1'b1;
    q.push_back(win_t'{w3(10, 11, 12), 1'b1});
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    send(8'd10, 1'b0);
    send(8'd11, 1'b0);
    send(8'd12, 1'b1);
    drain(50);

    // T6: reset mid-row with a held window
    sel = 0; out_ready_man = 1'b0;
    for (int k = 1; k <= 6; k++) send(8'(k), 1'b0);
    tick();
    chk("t6_pre_occupancy", 32'(occ_s), 32'd5);
    chk("t6_pre_out_valid", 32'(ov_s), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_in_ready", 32'(ir_s), 32'd0);
    rst = 1'b0;
    tick();
    chk("t6_post_out_valid", 32'(ov_s), 32'd0);
    chk("t6_post_out_last", 32'(ol_s), 32'd0);
    chk("t6_post_occupancy", 32'(occ_s), 32'd0);
    chk("t6_post_in_ready", 32'(ir_s), 32'd1);
    out_ready_man = 1'b1;
    q.push_back(win_t'{w3(20, 21, 22), 1'b1});
    send(8'd20, 1'b0);
    send(8'd21, 1'b0);
    send(8'd22, 1'b1);
    drain(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
